// File: rtl/serdes_pkg.sv
// Shared types and constants for the serial link receive path.
package serdes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RECV = 2'b01,
        HOLD = 2'b10
    } rx_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TRUNC   = 2'b01;
    localparam logic [1:0] ERR_OVERRUN = 2'b10;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/serdes_bit_sampler.sv
// Bit-period phase counter and mid-period sampler for the frame receiver.
// SERIAL_RX_MAJORITY_EN selects a 2-of-3 vote around the sample point.
module serdes_bit_sampler
    import serdes_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 active,
    input  logic [DIV_WIDTH-1:0] clk_div,
    input  logic                 serial_in,
    output logic                 sample_pt,
    output logic                 bit_strobe,
    output logic                 bit_val
);

    logic [DIV_WIDTH-1:0] div_r;
    logic [DIV_WIDTH-1:0] ph_r;
    logic [DIV_WIDTH-1:0] div_cur;
    logic [DIV_WIDTH-1:0] ph_cur;
    logic                 run;

    // The load cycle is phase 0 of bit 0, before the divider is latched.
    always_comb begin
        div_cur   = load ? clk_div : div_r;
        ph_cur    = load ? {DIV_WIDTH{1'b0}} : ph_r;
        run       = load | active;
        sample_pt = run && (ph_cur == (div_cur >> 1));
    end

    // Divider latch and phase counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r <= {DIV_WIDTH{1'b0}};
            ph_r  <= {DIV_WIDTH{1'b0}};
        end else begin
            if (load) begin
                div_r <= clk_div;
            end
            if (!run || (ph_cur == div_cur)) begin
                ph_r <= {DIV_WIDTH{1'b0}};
            end else begin
                ph_r <= ph_cur + DIV_WIDTH'(1);
            end
        end
    end

`ifdef SERIAL_RX_MAJORITY_EN
    logic prev_r;
    logic early_r;
    logic mid_r;
    logic pend_r;
    logic wide;

    // Dividers below 2 leave no room for neighbours, so they sample once.
    always_comb begin
        wide = (div_cur > DIV_WIDTH'(1));
        if (pend_r && active) begin
            bit_strobe = 1'b1;
            bit_val    = maj3(early_r, mid_r, serial_in);
        end else if (sample_pt && !wide) begin
            bit_strobe = 1'b1;
            bit_val    = serial_in;
        end else begin
            bit_strobe = 1'b0;
            bit_val    = 1'b0;
        end
    end

    // Vote history: the cycle before and the sample point itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r  <= 1'b0;
            early_r <= 1'b0;
            mid_r   <= 1'b0;
            pend_r  <= 1'b0;
        end else begin
            prev_r <= serial_in;
            pend_r <= sample_pt & wide;
            if (sample_pt) begin
                early_r <= prev_r;
                mid_r   <= serial_in;
            end
        end
    end
`else
    // Decision is the raw line value at the sample point.
    always_comb begin
        bit_strobe = sample_pt;
        bit_val    = serial_in;
    end
`endif

endmodule

// File: rtl/serial_frame_rx.sv
// Self-triggered framed serial receiver with valid/ready frame output.
// Define SERIAL_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
module serial_frame_rx
    import serdes_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 4,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  serial_in,
    input  logic                                  serial_en,
    input  logic [DIV_WIDTH-1:0]                  clk_div,
    input  logic [$clog2(DATA_WIDTH):0]           width,
    input  logic [$clog2(DATA_DEPTH):0]           depth,
    output logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] par_out,
    output logic                                  frame_valid,
    input  logic                                  frame_ready,
    output logic                                  frame_err,
    output logic [1:0]                            err_code,
    output logic                                  busy,
    output logic [$clog2(DATA_WIDTH):0]           bit_count,
    output logic [$clog2(DATA_DEPTH):0]           sample_count
);

    localparam int WW = $clog2(DATA_WIDTH) + 1;
    localparam int DW = $clog2(DATA_DEPTH) + 1;
    localparam int WI = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int DI = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam logic [WW-1:0] W_MAX = WW'(DATA_WIDTH - 1);
    localparam logic [DW-1:0] D_MAX = DW'(DATA_DEPTH - 1);

    rx_state_t state_r, state_next;
    logic          en_q;
    logic [WW-1:0] width_r;
    logic [DW-1:0] depth_r;

    logic          rise;
    logic          load;
    logic          in_recv;
    logic          receiving;
    logic          last_bit;
    logic          err_next;
    logic [1:0]    code_next;
    logic [WW-1:0] w_clamp, w_eff, bc_eff, bc_next;
    logic [DW-1:0] d_clamp, d_eff, sc_eff, sc_next;
    logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] par_next;

    logic sample_pt;
    logic bit_strobe;
    logic bit_val;

    assign in_recv = (state_r == RECV);

    serdes_bit_sampler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_sampler (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .active     (in_recv),
        .clk_div    (clk_div),
        .serial_in  (serial_in),
        .sample_pt  (sample_pt),
        .bit_strobe (bit_strobe),
        .bit_val    (bit_val)
    );

    // Next-state, frame assembly and error detection.
    always_comb begin
        rise      = serial_en & ~en_q;
        w_clamp   = (width > W_MAX) ? W_MAX : width;
        d_clamp   = (depth > D_MAX) ? D_MAX : depth;
        load      = 1'b0;
        state_next = state_r;
        err_next  = 1'b0;
        code_next = ERR_NONE;

        case (state_r)
            IDLE: begin
                if (rise) begin
                    load       = 1'b1;
                    state_next = RECV;
                end else begin
                    state_next = IDLE;
                end
            end
            RECV: begin
                state_next = RECV;
            end
            HOLD: begin
                // A rise alongside ready completes the handshake and starts over.
                if (frame_ready) begin
                    if (rise) begin
                        load       = 1'b1;
                        state_next = RECV;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (rise) begin
                    err_next   = 1'b1;
                    code_next  = ERR_OVERRUN;
                    state_next = HOLD;
                end else begin
                    state_next = HOLD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        receiving = load | in_recv;
        w_eff     = load ? w_clamp : width_r;
        d_eff     = load ? d_clamp : depth_r;
        bc_eff    = load ? {WW{1'b0}} : bit_count;
        sc_eff    = load ? {DW{1'b0}} : sample_count;
        last_bit  = (bc_eff == w_eff) && (sc_eff == d_eff);
        bc_next   = bc_eff;
        sc_next   = sc_eff;
        par_next  = par_out;

        if (receiving && sample_pt && !last_bit && !serial_en) begin
            err_next   = 1'b1;
            code_next  = ERR_TRUNC;
            state_next = IDLE;
        end else if (receiving && bit_strobe) begin
            par_next[sc_eff[DI-1:0]][bc_eff[WI-1:0]] = bit_val;
            if (last_bit) begin
                bc_next    = {WW{1'b0}};
                sc_next    = {DW{1'b0}};
                state_next = HOLD;
            end else if (bc_eff == w_eff) begin
                bc_next = {WW{1'b0}};
                sc_next = sc_eff + DW'(1);
            end else begin
                bc_next = bc_eff + WW'(1);
            end
        end else begin
            bc_next = bc_eff;
        end
    end

    // State, configuration latch and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            en_q         <= 1'b0;
            width_r      <= {WW{1'b0}};
            depth_r      <= {DW{1'b0}};
            bit_count    <= {WW{1'b0}};
            sample_count <= {DW{1'b0}};
            par_out      <= '0;
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
            err_code     <= ERR_NONE;
            busy         <= 1'b0;
        end else begin
            state_r      <= state_next;
            en_q         <= serial_en;
            if (load) begin
                width_r <= w_clamp;
                depth_r <= d_clamp;
            end
            bit_count    <= bc_next;
            sample_count <= sc_next;
            par_out      <= par_next;
            frame_valid  <= (state_next == HOLD);
            busy         <= (state_next == RECV);
            frame_err    <= err_next;
            err_code     <= code_next;
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed self-checking bench for serial_frame_rx with a serializer line model.
module tb_serial_frame_rx;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  serial_in;
    logic                  serial_en;
    logic [7:0]            clk_div;
    logic [5:0]            width;
    logic [2:0]            depth;
    logic [3:0][31:0]      par_out;
    logic                  frame_valid;
    logic                  frame_ready;
    logic                  frame_err;
    logic [1:0]            err_code;
    logic                  busy;
    logic [5:0]            bit_count;
    logic [2:0]            sample_count;

`ifdef SERIAL_RX_MAJORITY_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    serial_frame_rx #(
        .DATA_WIDTH (32),
        .DATA_DEPTH (4),
        .DIV_WIDTH  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .serial_en    (serial_en),
        .clk_div      (clk_div),
        .width        (width),
        .depth        (depth),
        .par_out      (par_out),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_err    (frame_err),
        .err_code     (err_code),
        .busy         (busy),
        .bit_count    (bit_count),
        .sample_count (sample_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one frame from a flat LSB-first bit stream; returns at posedge+1.
    task automatic run_frame(input logic [7:0] div, input logic [5:0] w, input logic [2:0] d,
                             input logic [127:0] bits, input int nbits, input int en_bits,
                             input int stop_cycles, input logic glitch, input logic ready0,
                             output int valid_cyc, output int err_cnt, output logic [1:0] last_code);
        int   total;
        int   k;
        int   ph;
        int   dv;
        logic prev_v;
        logic en_b;
        dv        = int'(div);
        total     = (stop_cycles > 0) ? stop_cycles : nbits * (dv + 1) + 6;
        valid_cyc = -1;
        err_cnt   = 0;
        last_code = 2'b00;
        clk_div   = div;
        width     = w;
        depth     = d;
        prev_v    = frame_valid;
        for (int c = 0; c < total; c++) begin
            k           = c / (dv + 1);
            ph          = c % (dv + 1);
            en_b        = (k < en_bits);
            serial_en   = en_b;
            serial_in   = en_b ? (bits[k] ^ (glitch && (ph == dv / 2))) : 1'b0;
            frame_ready = (c == 0) ? ready0 : 1'b0;
            @(negedge clk);
            if (frame_valid && !prev_v && valid_cyc < 0) valid_cyc = c;
            prev_v = frame_valid;
            if (frame_err) begin
                err_cnt++;
                last_code = err_code;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic accept_frame();
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
    endtask

    int         vc;
    int         ec;
    logic [1:0] code;

    initial begin
        rst         = 1'b1;
        serial_en   = 1'b0;
        serial_in   = 1'b0;
        frame_ready = 1'b0;
        clk_div     = 8'd3;
        width       = 6'd7;
        depth       = 3'd1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset_valid", frame_valid, 1'b0);
        check_eq("reset_busy", busy, 1'b0);
        check_eq("reset_err", frame_err, 1'b0);
        check_eq("reset_par", par_out, 128'h0);
        check_eq("reset_bitcnt", bit_count, 6'd0);
        @(posedge clk);
        #1;

        // Loopback: words 0xA5, 0x3C.
        run_frame(8'd3, 6'd7, 3'd1, 128'h3CA5, 16, 16, 0, 1'b0, 1'b0, vc, ec, code);
        check_eq("loop_valid_cycle", vc, 62 + LAT);
        check_eq("loop_par", par_out, 128'h0000003C_000000A5);
        check_eq("loop_err", ec, 0);

        // Backpressure: held frame stays put.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("bp_valid", frame_valid, 1'b1);
            check_eq("bp_par", par_out, 128'h0000003C_000000A5);
            @(posedge clk);
            #1;
        end

        // Overrun: new frame while held, no ready.
        run_frame(8'd3, 6'd7, 3'd1, 128'h2211, 16, 16, 0, 1'b0, 1'b0, vc, ec, code);
        check_eq("ovr_count", ec, 1);
        check_eq("ovr_code", code, 2'b10);
        check_eq("ovr_par_kept", par_out, 128'h0000003C_000000A5);
        check_eq("ovr_valid_kept", frame_valid, 1'b1);
        check_eq("ovr_no_new_rise", vc, -1);

        // Rise together with ready: handshake then receive.
        run_frame(8'd3, 6'd7, 3'd1, 128'hC35A, 16, 16, 0, 1'b0, 1'b1, vc, ec, code);
        check_eq("rr_err", ec, 0);
        check_eq("rr_valid_cycle", vc, 62 + LAT);
        check_eq("rr_par", par_out, 128'h000000C3_0000005A);

        // Plain handshake.
        frame_ready = 1'b1;
        @(negedge clk);
        check_eq("hs_valid_during", frame_valid, 1'b1);
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
        @(negedge clk);
        check_eq("hs_valid_after", frame_valid, 1'b0);
        check_eq("hs_busy_after", busy, 1'b0);
        @(posedge clk);
        #1;

        // Truncation after 4 bits; low nibble of word 0 overwritten only.
        run_frame(8'd3, 6'd7, 3'd0, 128'h0F, 8, 4, 0, 1'b0, 1'b0, vc, ec, code);
        check_eq("trunc_count", ec, 1);
        check_eq("trunc_code", code, 2'b01);
        check_eq("trunc_no_valid", vc, -1);
        check_eq("trunc_par", par_out, 128'h000000C3_0000005F);
        @(negedge clk);
        check_eq("trunc_idle", busy, 1'b0);
        check_eq("trunc_valid", frame_valid, 1'b0);
        @(posedge clk);
        #1;

`ifdef SERIAL_RX_MAJORITY_EN
        // Glitch at every sample point; the vote must reject it.
        run_frame(8'd7, 6'd15, 3'd0, 128'hBEEF, 16, 16, 0, 1'b1, 1'b0, vc, ec, code);
        check_eq("glitch_valid_cycle", vc, 125);
        check_eq("glitch_par", par_out, 128'h000000C3_0000BEEF);
        check_eq("glitch_err", ec, 0);
        accept_frame();
`endif

        // Reset at bit 5.
        run_frame(8'd3, 6'd7, 3'd1, 128'h6996, 16, 16, 21, 1'b0, 1'b0, vc, ec, code);
        check_eq("mid_busy", busy, 1'b1);
        check_eq("mid_bitcnt", bit_count, 6'd5);
        check_eq("mid_smpcnt", sample_count, 3'd0);
        rst       = 1'b1;
        serial_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_par", par_out, 128'h0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_valid", frame_valid, 1'b0);
        check_eq("rst_err", {frame_err, err_code}, 3'b000);
        check_eq("rst_counts", {bit_count, sample_count}, 9'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        run_frame(8'd3, 6'd7, 3'd1, 128'h6996, 16, 16, 0, 1'b0, 1'b0, vc, ec, code);
        check_eq("post_rst_valid_cycle", vc, 62 + LAT);
        check_eq("post_rst_par", par_out, 128'h00000069_00000096);
        check_eq("post_rst_err", ec, 0);
        accept_frame();
        @(negedge clk);
        check_eq("post_rst_released", frame_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
